data_memory_sync: RTL and testbench
===================================

Name: data_memory_sync

Overview:
Parametrised, clocked successor to the single-cycle combinational data memory. It serves MIPS-style loads and stores of byte, halfword and word size, with sign or zero extension on loads. Reads are registered with 1-cycle latency, and access uses a valid/ready request and response handshake. After reset, an optional clear sequence zeroes the whole array before the first request is accepted. The block sits in the MEM stage of the datapath.

Parameters:
DEPTH, 32, number of 32-bit words; any value ≥2; index width = clog2(DEPTH)
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned
CLEAR_ON_RESET, 1, 1 = zero every word after reset via CLEAR state; 0 = contents undefined after reset, no clear cycles

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present this cycle
req_ready  out  1  block can accept a request this cycle
addr  in  32  byte address
MemRead  in  1  load request
MemWrite  in  1  store request
size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
unsigned_ld  in  1  1 = zero-extend a sub-word load; 0 = sign-extend
WriteData  in  32  store data; the byte/half is taken from the low bits
resp_valid  out  1  response for the request accepted in the previous cycle
ReadData  out  32  load result; 0 on stores and on errors
err  out  1  the responded request was rejected; valid only with resp_valid

Behaviour:
- Reset: the clock and reset are one clock; reset is synchronous and active-high.
- Reset values: resp_valid=0, ReadData=0, err=0, clear counter=0.
- State after reset: CLEAR if CLEAR_ON_RESET=1, else IDLE.
- Reset asserted in any state, including mid-CLEAR, restarts from counter 0. Any pending response is dropped (resp_valid=0 next cycle).
- FSM CLEAR: req_ready=0. Writes 0 to word[cnt] each cycle, cnt 0..DEPTH-1, which takes exactly DEPTH cycles. The transition to IDLE follows the cycle that writes word DEPTH-1. req_valid is ignored during CLEAR.
- FSM IDLE: req_ready=1 continuously. One request accepted per cycle (req_valid & req_ready); no back-pressure on the response side.
- Index: idx = (addr - BASE_ADDR) >> 2.
- Error conditions, any of which sets err and suppresses the write:
  - addr < BASE_ADDR
  - idx ≥ DEPTH
  - size=11
  - size=01 with addr[0]=1
  - size=10 with addr[1:0]≠00
  - MemRead=MemWrite=1
- Accepted request with MemRead=MemWrite=0: no-op. resp_valid=1, err=0, ReadData=0.
- Byte lanes are little-endian: lane k = bits [8k+7:8k]. Byte offset = addr[1:0]; halfword offset = addr[1].
- Store: updates only the addressed lanes at the accepting edge; the other lanes are preserved.
  - Byte store writes WriteData[7:0]; half store writes WriteData[15:0].
- Load: reads the array at the accepting edge, before any same-edge write. The lane is extracted and extended per unsigned_ld, then registered into ReadData.
- Response: resp_valid=1 exactly one cycle after acceptance, together with ReadData and err. Otherwise resp_valid=0; ReadData holds its last value and err=0.
- Read-after-write: a store in cycle N followed by a load of the same word in cycle N+1 returns the stored data (response in cycle N+2).
- Memory is a registered array with one write port and one read port, no async read.
- Widths: idx truncates to clog2(DEPTH) bits only after the range check. The subtraction is 32-bit unsigned; a borrow means out of range.

Test Plan:
- Reset clear: DEPTH=32, CLEAR_ON_RESET=1, pulse reset 1 cycle → req_ready=0 for exactly 32 cycles then 1; word load at 0x7C → ReadData=0, err=0. Preload a word before reset and check it reads 0 afterwards.
- Sub-word store/load: SW 0x11223344 @0x08; SB 0xAB @0x09; LW @0x08 → 0x1122AB44. LB @0x09 → 0xFFFFFFAB; LBU → 0x000000AB; LH @0x0A → 0x00001122; LHU @0x08 → 0x0000AB44.
- Back-to-back throughput: SW 0xDEADBEEF @0x10 in cycle N, LW @0x10 in cycle N+1 → resp_valid in N+1 (store, ReadData=0) and N+2 (ReadData=0xDEADBEEF), no bubble.
- Errors, each checked with err=1 one cycle later and memory unchanged:
  - LW @0x02
  - LH @0x05
  - SW @0x80 (DEPTH=32)
  - size=11
  - MemRead=MemWrite=1
- Reset mid-clear: assert reset at clear cycle 10 → counter restarts, req_ready stays 0 for a further 32 cycles. Also reset on the cycle after a load is accepted → resp_valid=0 the following cycle.
- BASE_ADDR=0x1000_0000, CLEAR_ON_RESET=0: SW @0x1000_0004 then LW → data returned, err=0; LW @0x0FFF_FFFC → err=1.

Source files
------------

// File: rtl/data_memory_sync_if.sv
// Request/response bus of the clocked MEM-stage data memory.
// A request transfers on a rising edge where req_valid && req_ready; its response
// is presented for exactly one cycle afterwards with resp_valid=1 and cannot be stalled.
interface data_memory_sync_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] WriteData;
    logic        resp_valid;
    logic [31:0] ReadData;
    logic        err;

    modport master (
        output req_valid, addr, MemRead, MemWrite, size, unsigned_ld, WriteData,
        input  req_ready, resp_valid, ReadData, err
    );

    modport slave (
        input  req_valid, addr, MemRead, MemWrite, size, unsigned_ld, WriteData,
        output req_ready, resp_valid, ReadData, err
    );
endinterface

// File: rtl/data_memory_sync.sv
// Clocked byte/half/word data memory with registered load data and an optional
// post-reset clear sweep. fsm_state: 0 = CLEAR, 1 = IDLE.
module data_memory_sync #(
    parameter int          DEPTH          = 32,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    data_memory_sync_if.slave   bus,
    output logic                fsm_state
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

    state_t        state;
    logic [IW-1:0] cnt;
    logic [31:0]   mem [DEPTH];

    logic [31:0]   offset;
    logic [31:0]   word_off;
    logic [1:0]    lane;
    logic [IW-1:0] idx;
    logic          out_of_range;
    logic          bad_size;
    logic          bad_align;
    logic          bad_op;
    logic          req_err;
    logic          accept;
    logic          do_store;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   rword;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic [31:0]   load_data;

    assign fsm_state = state;

    // Range check uses the full 32-bit offset; idx is only meaningful when in range.
    always_comb begin
        offset       = bus.addr - BASE_ADDR;
        word_off     = {2'b00, offset[31:2]};
        lane         = offset[1:0];
        idx          = offset[IW+1:2];
        out_of_range = (bus.addr < BASE_ADDR) || (word_off >= 32'(DEPTH));
        bad_size     = (bus.size == 2'b11);
        bad_align    = ((bus.size == 2'b01) && lane[0]) ||
                       ((bus.size == 2'b10) && (lane != 2'b00));
        bad_op       = bus.MemRead && bus.MemWrite;
        req_err      = out_of_range || bad_size || bad_align || bad_op;
        accept       = bus.req_valid && bus.req_ready;
        do_store     = accept && bus.MemWrite && !req_err;
    end

    always_comb begin
        be    = 4'b0000;
        wdata = bus.WriteData;
        case (bus.size)
            2'b00: begin
                be    = 4'b0001 << lane;
                wdata = {4{bus.WriteData[7:0]}};
            end
            2'b01: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{bus.WriteData[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        rword     = mem[idx];
        rbyte     = rword[{lane, 3'b000} +: 8];
        rhalf     = lane[1] ? rword[31:16] : rword[15:0];
        load_data = '0;
        case (bus.size)
            2'b00:   load_data = bus.unsigned_ld ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
            2'b01:   load_data = bus.unsigned_ld ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
            2'b10:   load_data = rword;
            default: load_data = '0;
        endcase
    end

    // Single write port shared by the clear sweep and lane-enabled stores.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_CLEAR) begin
                mem[cnt] <= '0;
            end else if (do_store) begin
                for (int k = 0; k < 4; k++) begin
                    if (be[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            bus.req_ready  <= !CLEAR_ON_RESET;
            cnt            <= '0;
            bus.resp_valid <= 1'b0;
            bus.ReadData   <= '0;
            bus.err        <= 1'b0;
        end else begin
            bus.resp_valid <= accept;
            bus.err        <= accept && req_err;
            if (accept) begin
                bus.ReadData <= (bus.MemRead && !req_err) ? load_data : '0;
            end
            case (state)
                ST_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == IW'(DEPTH - 1)) begin
                        state         <= ST_IDLE;
                        bus.req_ready <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_sync.sv
// Scoreboard bench for data_memory_sync: dut_a clears on reset at base 0,
// dut_b has base 0x1000_0000 and no clear sweep.
module tb_data_memory_sync;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, reset_b;
    logic        sel;
    logic        req_valid, MemRead, MemWrite, unsigned_ld;
    logic [1:0]  size;
    logic [31:0] addr, WriteData;
    logic        state_a, state_b;

    data_memory_sync_if bus_a();
    data_memory_sync_if bus_b();

    assign bus_a.req_valid   = req_valid && !sel;
    assign bus_a.addr        = addr;
    assign bus_a.MemRead     = MemRead;
    assign bus_a.MemWrite    = MemWrite;
    assign bus_a.size        = size;
    assign bus_a.unsigned_ld = unsigned_ld;
    assign bus_a.WriteData   = WriteData;
    assign bus_b.req_valid   = req_valid && sel;
    assign bus_b.addr        = addr;
    assign bus_b.MemRead     = MemRead;
    assign bus_b.MemWrite    = MemWrite;
    assign bus_b.size        = size;
    assign bus_b.unsigned_ld = unsigned_ld;
    assign bus_b.WriteData   = WriteData;

    data_memory_sync #(.DEPTH(32), .BASE_ADDR(32'h0000_0000), .CLEAR_ON_RESET(1'b1)) dut_a (
        .clk(clk), .reset(reset_a), .bus(bus_a), .fsm_state(state_a)
    );
    data_memory_sync #(.DEPTH(32), .BASE_ADDR(32'h1000_0000), .CLEAR_ON_RESET(1'b0)) dut_b (
        .clk(clk), .reset(reset_b), .bus(bus_b), .fsm_state(state_b)
    );

    int          errors = 0;
    int          checks = 0;
    logic [32:0] exp_a[$];
    logic [32:0] exp_b[$];
    string       name_a[$];
    string       name_b[$];
    logic [32:0] pop_a, pop_b;
    string       pname_a, pname_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitors: compare every presented response against the scoreboard head.
    always @(negedge clk) begin
        if (bus_a.resp_valid === 1'b1) begin
            if (exp_a.size() == 0) begin
                check("a_unexpected_resp", 32'd1, 32'd0);
            end else begin
                pop_a   = exp_a.pop_front();
                pname_a = name_a.pop_front();
                check({pname_a, "_err"}, {31'b0, bus_a.err}, {31'b0, pop_a[32]});
                check({pname_a, "_data"}, bus_a.ReadData, pop_a[31:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (bus_b.resp_valid === 1'b1) begin
            if (exp_b.size() == 0) begin
                check("b_unexpected_resp", 32'd1, 32'd0);
            end else begin
                pop_b   = exp_b.pop_front();
                pname_b = name_b.pop_front();
                check({pname_b, "_err"}, {31'b0, bus_b.err}, {31'b0, pop_b[32]});
                check({pname_b, "_data"}, bus_b.ReadData, pop_b[31:0]);
            end
        end
    end

    // Driver: called #1 after a rising edge; request transfers on the next edge.
    task automatic send(input bit b, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd,
                        input logic e, input logic [31:0] d, input string name);
        sel = b;
        check({name, "_ready"}, {31'b0, (b ? bus_b.req_ready : bus_a.req_ready)}, 32'd1);
        if (b) begin exp_b.push_back({e, d}); name_b.push_back(name); end
        else   begin exp_a.push_back({e, d}); name_a.push_back(name); end
        req_valid = 1'b1; MemRead = rd; MemWrite = wr; size = sz;
        unsigned_ld = uns; addr = a; WriteData = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic sw(input bit b, input logic [31:0] a, input logic [31:0] d, input string name);
        send(b, 1'b0, 1'b1, 2'b10, 1'b0, a, d, 1'b0, 32'h0, name);
    endtask

    task automatic ld(input bit b, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                      input logic [31:0] d, input string name);
        send(b, 1'b1, 1'b0, sz, uns, a, 32'h0, 1'b0, d, name);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) begin
            if (exp_a.size() == 0 && exp_b.size() == 0) break;
            @(posedge clk); #1;
        end
        check("drain_pending", 32'(exp_a.size() + exp_b.size()), 32'd0);
    endtask

    task automatic pulse_reset_a();
        reset_a = 1'b1;
        @(posedge clk); #1;
        reset_a = 1'b0;
    endtask

    task automatic count_clear(output int n);
        n = 0;
        while (bus_a.req_ready !== 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_a = 1'b1; reset_b = 1'b1; sel = 1'b0;
        req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; size = 2'b10;
        unsigned_ld = 1'b0; addr = '0; WriteData = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", {31'b0, bus_a.resp_valid}, 32'd0);
        check("rst_read_data", bus_a.ReadData, 32'd0);
        check("rst_err", {31'b0, bus_a.err}, 32'd0);
        check("rst_ready_a", {31'b0, bus_a.req_ready}, 32'd0);
        check("rst_state_a", {31'b0, state_a}, 32'd0);
        check("rst_ready_b", {31'b0, bus_b.req_ready}, 32'd1);
        check("rst_state_b", {31'b0, state_b}, 32'd1);
        check("rst_resp_valid_b", {31'b0, bus_b.resp_valid}, 32'd0);
        reset_a = 1'b0; reset_b = 1'b0;

        count_clear(n);
        check("clear_cycles", 32'(n), 32'd32);
        check("clear_done_state", {31'b0, state_a}, 32'd1);
        ld(0, 2'b10, 1'b0, 32'h7C, 32'h0, "clr_lw_7c");
        sw(0, 32'h7C, 32'h1234_5678, "pre_sw_7c");
        ld(0, 2'b10, 1'b0, 32'h7C, 32'h1234_5678, "pre_lw_7c");
        drain();
        pulse_reset_a();
        count_clear(n);
        check("reclear_cycles", 32'(n), 32'd32);
        ld(0, 2'b10, 1'b0, 32'h7C, 32'h0, "wiped_lw_7c");

        sw(0, 32'h08, 32'h1122_3344, "sw_08");
        send(0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h09, 32'hFFFF_FFAB, 1'b0, 32'h0, "sb_09");
        ld(0, 2'b10, 1'b0, 32'h08, 32'h1122_AB44, "lw_08");
        ld(0, 2'b00, 1'b0, 32'h09, 32'hFFFF_FFAB, "lb_09");
        ld(0, 2'b00, 1'b1, 32'h09, 32'h0000_00AB, "lbu_09");
        ld(0, 2'b01, 1'b0, 32'h0A, 32'h0000_1122, "lh_0a");
        ld(0, 2'b01, 1'b1, 32'h08, 32'h0000_AB44, "lhu_08");
        ld(0, 2'b01, 1'b0, 32'h08, 32'hFFFF_AB44, "lh_08");
        send(0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0A, 32'h5555_8001, 1'b0, 32'h0, "sh_0a");
        ld(0, 2'b10, 1'b0, 32'h08, 32'h8001_AB44, "lw_08_after_sh");
        ld(0, 2'b01, 1'b1, 32'h0A, 32'h0000_8001, "lhu_0a");
        ld(0, 2'b00, 1'b0, 32'h0B, 32'hFFFF_FF80, "lb_0b");
        drain();

        sw(0, 32'h10, 32'hDEAD_BEEF, "b2b_sw_10");
        check("b2b_store_resp_valid", {31'b0, bus_a.resp_valid}, 32'd1);
        ld(0, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, "b2b_lw_10");
        check("b2b_load_resp_valid", {31'b0, bus_a.resp_valid}, 32'd1);
        drain();

        sw(0, 32'h00, 32'hA5A5_A5A5, "sw_00");
        sw(0, 32'h04, 32'h5A5A_5A5A, "sw_04");
        send(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 1'b1, 32'h0, "err_lw_02");
        send(0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h05, 32'h0, 1'b1, 32'h0, "err_lh_05");
        send(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h80, 32'hFFFF_FFFF, 1'b1, 32'h0, "err_sw_80");
        send(0, 1'b0, 1'b1, 2'b11, 1'b0, 32'h04, 32'h0, 1'b1, 32'h0, "err_size11");
        send(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h00, 32'h0, 1'b1, 32'h0, "err_rd_wr");
        ld(0, 2'b10, 1'b0, 32'h00, 32'hA5A5_A5A5, "unchanged_00");
        ld(0, 2'b10, 1'b0, 32'h04, 32'h5A5A_5A5A, "unchanged_04");
        send(0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h20, 32'hFFFF, 1'b0, 32'h0, "noop_20");
        drain();

        pulse_reset_a();
        repeat (10) @(posedge clk);
        #1;
        check("mid_clear_ready", {31'b0, bus_a.req_ready}, 32'd0);
        pulse_reset_a();
        count_clear(n);
        check("mid_clear_restart_cycles", 32'(n), 32'd32);

        ld(0, 2'b10, 1'b0, 32'h10, 32'h0, "lw_before_reset");
        reset_a = 1'b1;
        @(posedge clk); #1;
        check("rst_drops_resp_valid", {31'b0, bus_a.resp_valid}, 32'd0);
        reset_a = 1'b0;
        count_clear(n);
        check("post_drop_clear_cycles", 32'(n), 32'd32);
        drain();

        sw(1, 32'h1000_0004, 32'hCAFE_F00D, "b_sw_04");
        ld(1, 2'b10, 1'b0, 32'h1000_0004, 32'hCAFE_F00D, "b_lw_04");
        send(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0FFF_FFFC, 32'h0, 1'b1, 32'h0, "b_err_below_base");
        send(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h1000_0080, 32'h0, 1'b1, 32'h0, "b_err_past_end");
        ld(1, 2'b00, 1'b0, 32'h1000_0007, 32'hFFFF_FFCA, "b_lb_07");
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
